// File: rtl/jk_ff_tester.sv
// jk_ff_tester: drives the negative-edge JK flip-flop cell through a clear,
// a preset and REPEAT passes of an 8-entry JK vector table. It compares
// Q/Q_ against an internal model one cycle after each stimulus, and reports
// pass, a saturating error count and the index of the first failing check.
module jk_ff_tester #(
    parameter int unsigned REPEAT = 1
) (
    input  logic       cp,
    input  logic       r_,
    input  logic       start,
    input  logic       dut_q,
    input  logic       dut_q_,
    output logic       dut_j,
    output logic       dut_k,
    output logic       dut_s_,
    output logic       dut_r_,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] fail_idx
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SET,
        RUN,
        LAST,
        DONE
    } state_t;

    // Pass counter value of the final pass through the vector table.
    localparam logic [4:0] LAST_PASS = 5'(REPEAT - 1);
    localparam logic [7:0] NO_FAIL   = 8'hFF;

    // Fixed JK stimulus table, returned as {j,k}.
    function automatic logic [1:0] vec_jk(input logic [2:0] step);
        logic [1:0] jk;
        case (step)
            3'd0:    jk = 2'b00;
            3'd1:    jk = 2'b01;
            3'd2:    jk = 2'b10;
            3'd3:    jk = 2'b11;
            3'd4:    jk = 2'b11;
            3'd5:    jk = 2'b00;
            3'd6:    jk = 2'b10;
            default: jk = 2'b01;
        endcase
        return jk;
    endfunction

    // Reference JK behaviour: hold, clear, set, toggle.
    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic nq;
        case (jk)
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [4:0] pcnt_q, pcnt_d;
    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       set_n_q, set_n_d;
    logic       clr_n_q, clr_n_d;
    logic       qexp_q, qexp_d;
    logic       chk_pend_q, chk_pend_d;
    logic [7:0] chk_idx_q, chk_idx_d;
    logic       chk_exp_q, chk_exp_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] err_q, err_d;
    logic [7:0] fidx_q, fidx_d;

    logic       chk_fail;
    logic [2:0] step_nx;
    logic [4:0] pcnt_nx;
    logic [1:0] jk_nx;
    logic       q_nx;
    logic [1:0] jk_first;
    logic       q_first;

    // A pending check fails on a wrong Q or on Q_ not being the complement of Q.
    always_comb begin
        chk_fail = chk_pend_q && ((dut_q != chk_exp_q) || (dut_q_ == dut_q));
    end

    // Next table position and model value while walking the vector table.
    always_comb begin
        step_nx  = step_q + 3'd1;
        pcnt_nx  = (step_q == 3'd7) ? pcnt_q + 5'd1 : pcnt_q;
        jk_nx    = vec_jk(step_nx);
        q_nx     = jk_next(qexp_q, jk_nx);
        jk_first = vec_jk(3'd0);
        q_first  = jk_next(qexp_q, jk_first);
    end

    // Sequencer next-state, stimulus and result bookkeeping.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        pcnt_d     = pcnt_q;
        j_d        = j_q;
        k_d        = k_q;
        set_n_d    = set_n_q;
        clr_n_d    = clr_n_q;
        qexp_d     = qexp_q;
        chk_pend_d = 1'b0;
        chk_idx_d  = chk_idx_q;
        chk_exp_d  = chk_exp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        fidx_d     = fidx_q;

        if (chk_fail) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (fidx_q == NO_FAIL) begin
                fidx_d = chk_idx_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CLR;
                    busy_d     = 1'b1;
                    err_d      = 8'd0;
                    pass_d     = 1'b0;
                    fidx_d     = NO_FAIL;
                    j_d        = 1'b0;
                    k_d        = 1'b0;
                    clr_n_d    = 1'b0;
                    qexp_d     = 1'b0;
                    chk_pend_d = 1'b1;
                    chk_idx_d  = 8'd0;
                    chk_exp_d  = 1'b0;
                end
            end
            CLR: begin
                state_d    = SET;
                clr_n_d    = 1'b1;
                set_n_d    = 1'b0;
                qexp_d     = 1'b1;
                chk_pend_d = 1'b1;
                chk_idx_d  = 8'd1;
                chk_exp_d  = 1'b1;
            end
            SET: begin
                state_d    = RUN;
                set_n_d    = 1'b1;
                step_d     = 3'd0;
                pcnt_d     = 5'd0;
                {j_d, k_d} = jk_first;
                qexp_d     = q_first;
                chk_pend_d = 1'b1;
                chk_idx_d  = 8'd2;
                chk_exp_d  = q_first;
            end
            RUN: begin
                if ((step_q == 3'd7) && (pcnt_q == LAST_PASS)) begin
                    state_d = LAST;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end else begin
                    step_d     = step_nx;
                    pcnt_d     = pcnt_nx;
                    {j_d, k_d} = jk_nx;
                    qexp_d     = q_nx;
                    chk_pend_d = 1'b1;
                    chk_idx_d  = {pcnt_nx, step_nx} + 8'd2;
                    chk_exp_d  = q_nx;
                end
            end
            LAST: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == 8'd0);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the flip-flop pins at once.
    always_ff @(posedge cp or negedge r_) begin
        if (!r_) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            pcnt_q     <= 5'd0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            set_n_q    <= 1'b1;
            clr_n_q    <= 1'b1;
            qexp_q     <= 1'b0;
            chk_pend_q <= 1'b0;
            chk_idx_q  <= 8'd0;
            chk_exp_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 8'd0;
            fidx_q     <= NO_FAIL;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            pcnt_q     <= pcnt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            set_n_q    <= set_n_d;
            clr_n_q    <= clr_n_d;
            qexp_q     <= qexp_d;
            chk_pend_q <= chk_pend_d;
            chk_idx_q  <= chk_idx_d;
            chk_exp_q  <= chk_exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fidx_q     <= fidx_d;
        end
    end

    assign dut_j    = j_q;
    assign dut_k    = k_q;
    assign dut_s_   = set_n_q;
    assign dut_r_   = clr_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_idx = fidx_q;

endmodule
